// File: rtl/axi_pkg.sv
// Shared AXI4 types and encodings for the DMA master and the memory-backed responder.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_STRB_W-1:0] axi_strb_t;
    typedef logic [AXI_ID_W-1:0]   axi_id_t;
    typedef logic [7:0]            axi_len_t;
    typedef logic [2:0]            axi_size_t;
    typedef logic [1:0]            axi_burst_t;
    typedef logic [1:0]            axi_resp_code_t;

    localparam axi_resp_code_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_code_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_code_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_code_t AXI_RESP_DECERR = 2'b11;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        axi_id_t    awid;
        axi_addr_t  awaddr;
        axi_len_t   awlen;
        axi_size_t  awsize;
        axi_burst_t awburst;
        logic       awvalid;
        axi_data_t  wdata;
        axi_strb_t  wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
        axi_id_t    arid;
        axi_addr_t  araddr;
        axi_len_t   arlen;
        axi_size_t  arsize;
        axi_burst_t arburst;
        logic       arvalid;
        logic       rready;
    } axi_req_t;

    typedef struct packed {
        logic           awready;
        logic           wready;
        logic           bvalid;
        axi_id_t        bid;
        axi_resp_code_t bresp;
        logic           arready;
        logic           rvalid;
        axi_id_t        rid;
        axi_data_t      rdata;
        axi_resp_code_t rresp;
        logic           rlast;
    } axi_resp_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } s_axi_slv_rd_st_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } s_axi_slv_wr_st_t;

    // Response chosen at address time; decode errors outrank unsupported burst types.
    function automatic axi_resp_code_t axi_start_resp(input logic out_of_range, input axi_burst_t burst);
        if (out_of_range)
            return AXI_RESP_DECERR;
        else if (burst != AXI_BURST_INCR)
            return AXI_RESP_SLVERR;
        else
            return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dma_axi_slave_ram.sv
// Word array with per-byte write enables and an asynchronous read port.
module dma_axi_slave_ram
    import axi_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  axi_data_t        wdata,
    input  axi_strb_t        wstrb,
    input  logic [IDX_W-1:0] raddr,
    output axi_data_t        rdata
);

    axi_data_t mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (wstrb[i])
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_axi_slave_mem.sv
// AXI4 responder backed by a word array; independent read and write engines, one burst each.
//
// state   | meaning
// RD_IDLE | arready offered, waiting for an AR handshake
// RD_DATA | streaming R beats until the rlast handshake
// WR_IDLE | awready offered, W not accepted
// WR_DATA | accepting W beats until wlast
// WR_RESP | presenting B until bready
module dma_axi_slave_mem
    import axi_pkg::*;
#(
    parameter int        MEM_WORDS = 1024,
    parameter axi_addr_t BASE_ADDR = 32'h0000_0000,
    parameter bit        STALL_EN  = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o,
    input  logic      stall_i,
    output logic      busy_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OFF_W = $clog2(AXI_STRB_W);

    s_axi_slv_rd_st_t rd_state, rd_next;
    s_axi_slv_wr_st_t wr_state, wr_next;

    logic             stall;
    logic             ar_ready, r_valid, aw_ready, w_ready, b_valid;
    logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;

    axi_addr_t        ar_word, aw_word;
    logic             ar_oor, aw_oor;
    axi_resp_code_t   ar_start, aw_start;

    logic [IDX_W:0]   rd_idx, wr_idx;
    axi_len_t         rd_len, wr_len, rd_beat;
    logic [8:0]       wr_beat;
    axi_id_t          rd_id, wr_id;
    axi_resp_code_t   rd_resp, wr_resp;
    logic             r_last, r_dec, w_dec, w_over, w_early;
    axi_data_t        ram_rdata;
    logic             unused_size;

    assign stall = STALL_EN && stall_i;
    assign unused_size = ^{axi_req_i.arsize, axi_req_i.awsize};

    // Address decode: index is the word offset from BASE_ADDR, low byte bits dropped.
    assign ar_word  = (axi_req_i.araddr - BASE_ADDR) >> OFF_W;
    assign aw_word  = (axi_req_i.awaddr - BASE_ADDR) >> OFF_W;
    assign ar_oor   = (axi_req_i.araddr < BASE_ADDR) || (ar_word >= AXI_ADDR_W'(MEM_WORDS));
    assign aw_oor   = (axi_req_i.awaddr < BASE_ADDR) || (aw_word >= AXI_ADDR_W'(MEM_WORDS));
    assign ar_start = axi_start_resp(ar_oor, axi_req_i.arburst);
    assign aw_start = axi_start_resp(aw_oor, axi_req_i.awburst);

    assign ar_hs = axi_req_i.arvalid && ar_ready;
    assign r_hs  = r_valid && axi_req_i.rready;
    assign aw_hs = axi_req_i.awvalid && aw_ready;
    assign w_hs  = axi_req_i.wvalid && w_ready;
    assign b_hs  = b_valid && axi_req_i.bready;

    // The top index bit flags a burst that ran off the end of the array.
    assign r_last  = (rd_beat == rd_len);
    assign r_dec   = (rd_resp == AXI_RESP_DECERR) || rd_idx[IDX_W];
    assign w_dec   = (wr_resp == AXI_RESP_DECERR) || wr_idx[IDX_W];
    assign w_over  = (wr_beat > {1'b0, wr_len});
    assign w_early = axi_req_i.wlast && (wr_beat < {1'b0, wr_len});

    always_comb begin : rd_fsm_comb
        rd_next  = rd_state;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        if (!rst) begin
            unique case (rd_state)
                RD_IDLE: begin
                    ar_ready = !stall;
                    if (ar_hs)
                        rd_next = RD_DATA;
                end
                RD_DATA: begin
                    r_valid = !stall;
                    if (r_hs && r_last)
                        rd_next = RD_IDLE;
                end
                default: rd_next = RD_IDLE;
            endcase
        end
    end

    always_comb begin : wr_fsm_comb
        wr_next  = wr_state;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        if (!rst) begin
            unique case (wr_state)
                WR_IDLE: begin
                    aw_ready = !stall;
                    if (aw_hs)
                        wr_next = WR_DATA;
                end
                WR_DATA: begin
                    w_ready = !stall;
                    if (w_hs && axi_req_i.wlast)
                        wr_next = WR_RESP;
                end
                WR_RESP: begin
                    b_valid = !stall;
                    if (b_hs)
                        wr_next = WR_IDLE;
                end
                default: wr_next = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_idx   <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_id    <= '0;
            rd_resp  <= AXI_RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rd_idx  <= {1'b0, ar_word[IDX_W-1:0]};
                rd_len  <= axi_req_i.arlen;
                rd_beat <= '0;
                rd_id   <= axi_req_i.arid;
                rd_resp <= ar_start;
            end else if (r_hs) begin
                rd_beat <= rd_beat + 8'd1;
                if (!rd_idx[IDX_W])
                    rd_idx <= rd_idx + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_idx   <= '0;
            wr_len   <= '0;
            wr_beat  <= '0;
            wr_id    <= '0;
            wr_resp  <= AXI_RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                wr_idx  <= {1'b0, aw_word[IDX_W-1:0]};
                wr_len  <= axi_req_i.awlen;
                wr_beat <= '0;
                wr_id   <= axi_req_i.awid;
                wr_resp <= aw_start;
            end else if (w_hs) begin
                if (!wr_idx[IDX_W])
                    wr_idx <= wr_idx + (IDX_W+1)'(1);
                if (wr_beat != '1)
                    wr_beat <= wr_beat + 9'd1;
                if (w_dec)
                    wr_resp <= AXI_RESP_DECERR;
                else if (w_over || w_early)
                    wr_resp <= AXI_RESP_SLVERR;
            end
        end
    end

    dma_axi_slave_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_hs && !w_dec),
        .waddr (wr_idx[IDX_W-1:0]),
        .wdata (axi_req_i.wdata),
        .wstrb (axi_req_i.wstrb),
        .raddr (rd_idx[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin : resp_comb
        axi_resp_o         = '0;
        axi_resp_o.arready = ar_ready;
        axi_resp_o.rvalid  = r_valid;
        axi_resp_o.awready = aw_ready;
        axi_resp_o.wready  = w_ready;
        axi_resp_o.bvalid  = b_valid;
        // R and B payloads follow the state, not valid, so they hold through a stall.
        if (!rst && rd_state == RD_DATA) begin
            axi_resp_o.rid   = rd_id;
            axi_resp_o.rdata = r_dec ? '0 : ram_rdata;
            axi_resp_o.rresp = r_dec ? AXI_RESP_DECERR : rd_resp;
            axi_resp_o.rlast = r_last;
        end
        if (!rst && wr_state == WR_RESP) begin
            axi_resp_o.bid   = wr_id;
            axi_resp_o.bresp = wr_resp;
        end
    end

    assign busy_o = (rd_state != RD_IDLE) || (wr_state != WR_IDLE);

endmodule
